// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SETUP,
      S_ADDR,
      S_SMDR,
      S_SMEM,
      S_LMEM,
      S_LRF,
      S_NEXT,
      S_WB,
      S_DONE
   } state_t;

   localparam int ADDR_STEP = 4;
   localparam int MAX_WAIT  = 15;

   // Instruction field positions (ARM addressing mode 4)
   localparam int IR_CLASS_MSB = 27;
   localparam int IR_CLASS_LSB = 25;
   localparam int IR_P         = 24;
   localparam int IR_U         = 23;
   localparam int IR_W         = 21;
   localparam int IR_L         = 20;
   localparam int IR_RN_MSB    = 19;
   localparam int IR_RN_LSB    = 16;
   localparam int IR_LIST_MSB  = 15;
   localparam int IR_LIST_LSB  = 0;

   localparam logic [2:0] CLASS_BLOCK = 3'b100;

endpackage

// File: rtl/reg_list_scan.sv
// Lowest-set-bit priority encoder and population count of a 16-bit register list.
module reg_list_scan (
   input  logic [15:0] list,
   output logic [3:0]  lowest,
   output logic [4:0]  count
);

   always_comb begin
      lowest = 4'd0;
      count  = 5'd0;
      // Scanning downward lets the lowest set bit overwrite any higher one.
      for (int i = 15; i >= 0; i--) begin
         if (list[i]) begin
            lowest = i[3:0];
         end
         count = count + {4'd0, list[i]};
      end
   end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer over the MAR/MDR/RF datapath.
// Optional MOC wait timeout enabled by defining MOC_TIMEOUT_EN.
module ldm_stm_sequencer
   import ldm_stm_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [31:0] IR,
   input  logic [31:0] base,
   input  logic        MOC,
   output logic        busy,
   output logic        done,
   output logic        MAR_ld,
   output logic        MDR_ld,
   output logic        RF_ld,
   output logic        R_W,
   output logic        MOV,
   output logic [3:0]  reg_sel,
   output logic [31:0] mem_addr,
   output logic        wb_ld,
   output logic [31:0] wb_value,
   output logic        err
);

   state_t      state_reg, state_next;
   logic        p_reg, u_reg, w_reg, l_reg;
   logic [3:0]  rn_reg;
   logic [15:0] orig_list_reg, list_reg;
   logic [31:0] base_reg, addr_reg, mem_addr_reg, wb_value_reg;
   logic [3:0]  reg_sel_reg;

   logic [3:0]  scan_lowest;
   logic [4:0]  scan_count;
   logic        accept, timeout, in_mem;
   logic [15:0] list_cleared;
   logic [31:0] span, start_addr;

   logic unused_ir_bits;
   assign unused_ir_bits = ^{IR[31:28], IR[22]};

   reg_list_scan u_scan (
      .list   (list_reg),
      .lowest (scan_lowest),
      .count  (scan_count)
   );

   assign accept = (state_reg == S_IDLE) && start &&
                   (IR[IR_CLASS_MSB:IR_CLASS_LSB] == CLASS_BLOCK);
   assign in_mem = (state_reg == S_SMEM) || (state_reg == S_LMEM);
   assign list_cleared = list_reg & ~(16'd1 << reg_sel_reg);
   assign span = 32'(ADDR_STEP) * {27'd0, scan_count};

   always_comb begin
      case ({p_reg, u_reg})
         2'b01:   start_addr = base_reg;
         2'b11:   start_addr = base_reg + 32'(ADDR_STEP);
         2'b00:   start_addr = base_reg - span + 32'(ADDR_STEP);
         default: start_addr = base_reg - span;
      endcase
   end

`ifdef MOC_TIMEOUT_EN
   logic [3:0] wait_reg;
   logic       err_reg;

   // Counter restarts on every entry because it is held at zero outside the memory states.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wait_reg <= 4'd0;
         err_reg  <= 1'b0;
      end else begin
         wait_reg <= in_mem ? wait_reg + 4'd1 : 4'd0;
         if (accept) begin
            err_reg <= 1'b0;
         end else if (timeout) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign timeout = in_mem && !MOC && (wait_reg == 4'(MAX_WAIT - 1));
   assign err     = err_reg;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      MAR_ld     = 1'b0;
      MDR_ld     = 1'b0;
      RF_ld      = 1'b0;
      R_W        = 1'b0;
      MOV        = 1'b0;
      wb_ld      = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (accept) state_next = S_SETUP;
         end
         S_SETUP: begin
            state_next = (scan_count == 5'd0) ? S_DONE : S_ADDR;
         end
         S_ADDR: begin
            MAR_ld     = 1'b1;
            state_next = l_reg ? S_LMEM : S_SMDR;
         end
         S_SMDR: begin
            MDR_ld     = 1'b1;
            state_next = S_SMEM;
         end
         S_SMEM: begin
            MOV = 1'b1;
            if (MOC)          state_next = S_NEXT;
            else if (timeout) state_next = S_DONE;
         end
         S_LMEM: begin
            MOV    = 1'b1;
            R_W    = 1'b1;
            MDR_ld = 1'b1;
            if (MOC)          state_next = S_LRF;
            else if (timeout) state_next = S_DONE;
         end
         S_LRF: begin
            RF_ld      = 1'b1;
            state_next = S_NEXT;
         end
         S_NEXT: begin
            state_next = (list_cleared == 16'd0) ? S_WB : S_ADDR;
         end
         S_WB: begin
            // A loaded base register takes precedence over the writeback.
            wb_ld      = w_reg && !(l_reg && orig_list_reg[rn_reg]);
            state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign busy     = (state_reg != S_IDLE);
   assign reg_sel  = (state_reg == S_ADDR) ? scan_lowest : reg_sel_reg;
   assign mem_addr = (state_reg == S_ADDR) ? addr_reg : mem_addr_reg;
   assign wb_value = wb_value_reg;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         p_reg         <= 1'b0;
         u_reg         <= 1'b0;
         w_reg         <= 1'b0;
         l_reg         <= 1'b0;
         rn_reg        <= 4'd0;
         orig_list_reg <= 16'd0;
         list_reg      <= 16'd0;
         base_reg      <= 32'd0;
         addr_reg      <= 32'd0;
         mem_addr_reg  <= 32'd0;
         wb_value_reg  <= 32'd0;
         reg_sel_reg   <= 4'd0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  p_reg         <= IR[IR_P];
                  u_reg         <= IR[IR_U];
                  w_reg         <= IR[IR_W];
                  l_reg         <= IR[IR_L];
                  rn_reg        <= IR[IR_RN_MSB:IR_RN_LSB];
                  orig_list_reg <= IR[IR_LIST_MSB:IR_LIST_LSB];
                  list_reg      <= IR[IR_LIST_MSB:IR_LIST_LSB];
                  base_reg      <= base;
               end
            end
            S_SETUP: begin
               addr_reg     <= start_addr;
               wb_value_reg <= u_reg ? base_reg + span : base_reg - span;
            end
            S_ADDR: begin
               mem_addr_reg <= addr_reg;
               reg_sel_reg  <= scan_lowest;
            end
            S_NEXT: begin
               list_reg <= list_cleared;
               addr_reg <= addr_reg + 32'(ADDR_STEP);
            end
            S_DONE: begin
               list_reg <= 16'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed, table-driven bench for ldm_stm_sequencer (timeout case only with MOC_TIMEOUT_EN).
module tb_ldm_stm_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic [31:0] IR = 32'd0;
   logic [31:0] base = 32'd0;
   logic        MOC = 1'b0;
   logic        busy, done, MAR_ld, MDR_ld, RF_ld, R_W, MOV, wb_ld, err;
   logic [3:0]  reg_sel;
   logic [31:0] mem_addr, wb_value;

   int total = 0;
   int bad   = 0;

   ldm_stm_sequencer dut (
      .clk      (clk),
      .clr      (clr),
      .start    (start),
      .IR       (IR),
      .base     (base),
      .MOC      (MOC),
      .busy     (busy),
      .done     (done),
      .MAR_ld   (MAR_ld),
      .MDR_ld   (MDR_ld),
      .RF_ld    (RF_ld),
      .R_W      (R_W),
      .MOV      (MOV),
      .reg_sel  (reg_sel),
      .mem_addr (mem_addr),
      .wb_ld    (wb_ld),
      .wb_value (wb_value),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      ir;
      logic [31:0]      base;
      int               delay;
      int               poke;
      int               n;
      logic [2:0][31:0] addr;
      logic [2:0][3:0]  regs;
      logic             is_load;
      logic             wb;
      logic [31:0]      wbv;
      int               lat;
      int               mov;
      logic             err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [31:0] ir, input logic [31:0] b, input int delay,
                               input int poke, input int n,
                               input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                               input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                               input logic ld, input logic wb, input logic [31:0] wbv,
                               input int lat, input int mov, input logic e);
      vec_t v;
      v.ir = ir; v.base = b; v.delay = delay; v.poke = poke; v.n = n;
      v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
      v.regs[0] = r0; v.regs[1] = r1; v.regs[2] = r2;
      v.is_load = ld; v.wb = wb; v.wbv = wbv; v.lat = lat; v.mov = mov; v.err = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          cyc, done_cyc, mar_n, rf_n, mov_n, rw_bad, mov_seen;
      logic        wb_seen;
      logic [31:0] wbv_seen;
      logic [31:0] addr_q[$];
      logic [3:0]  mreg_q[$];
      logic [3:0]  rreg_q[$];
      done_cyc = -1; mar_n = 0; rf_n = 0; mov_n = 0; rw_bad = 0; mov_seen = 0;
      wb_seen = 1'b0; wbv_seen = 32'd0;
      @(negedge clk);
      IR = v.ir; base = v.base; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("v%0d_busy_setup", idx), {63'd0, busy}, 64'd1);
      for (cyc = 1; cyc <= 60; cyc++) begin
         if (v.poke != 0 && cyc == v.poke) begin
            start = 1'b1; IR = 32'hE8900000;
         end else begin
            start = 1'b0; IR = v.ir;
         end
         if (MAR_ld) begin
            addr_q.push_back(mem_addr); mreg_q.push_back(reg_sel); mar_n++;
         end
         if (RF_ld) begin
            rreg_q.push_back(reg_sel); rf_n++;
         end
         if (MOV) begin
            mov_n++;
            if (R_W !== v.is_load) rw_bad++;
         end
         if (wb_ld) begin
            wb_seen = 1'b1; wbv_seen = wb_value;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (MOV) begin
            MOC = (mov_seen == v.delay);
            mov_seen++;
         end else begin
            MOC = 1'b0; mov_seen = 0;
         end
         @(negedge clk);
      end
      MOC = 1'b0; start = 1'b0;
      check($sformatf("v%0d_done_latency", idx), 64'(done_cyc), 64'(v.lat));
      check($sformatf("v%0d_mar_count", idx), 64'(mar_n), 64'(v.n));
      for (int k = 0; k < v.n && k < mar_n; k++) begin
         check($sformatf("v%0d_addr%0d", idx, k), {32'd0, addr_q[k]}, {32'd0, v.addr[k]});
         check($sformatf("v%0d_reg%0d", idx, k), {60'd0, mreg_q[k]}, {60'd0, v.regs[k]});
      end
      check($sformatf("v%0d_rf_count", idx), 64'(rf_n), v.is_load ? 64'(v.n) : 64'd0);
      for (int k = 0; k < rf_n && k < v.n; k++) begin
         check($sformatf("v%0d_rfreg%0d", idx, k), {60'd0, rreg_q[k]}, {60'd0, v.regs[k]});
      end
      check($sformatf("v%0d_mov_cycles", idx), 64'(mov_n), 64'(v.mov));
      check($sformatf("v%0d_rw_bad", idx), 64'(rw_bad), 64'd0);
      check($sformatf("v%0d_wb_ld", idx), {63'd0, wb_seen}, {63'd0, v.wb});
      if (v.wb) check($sformatf("v%0d_wb_at_ld", idx), {32'd0, wbv_seen}, {32'd0, v.wbv});
      check($sformatf("v%0d_wb_value", idx), {32'd0, wb_value}, {32'd0, v.wbv});
      check($sformatf("v%0d_err", idx), {63'd0, err}, {63'd0, v.err});
      @(negedge clk);
      check($sformatf("v%0d_idle_after", idx), {63'd0, busy}, 64'd0);
      $display("vec %0d ir=%h base=%h done_cyc=%0d mar=%0d rf=%0d mov=%0d wb=%0b",
               idx, v.ir, v.base, done_cyc, mar_n, rf_n, mov_n, wb_seen);
   endtask

   initial begin
      int found;
      //          ir            base          dly poke n  a0            a1            a2           r0 r1 r2 ld wb wbv           lat mov err
      vecs.push_back(mk(32'hE8A0000A, 32'h100,     0, 3, 2, 32'h100,      32'h104,      0,           1, 3, 0, 0, 1, 32'h108,      11, 2, 0));
      vecs.push_back(mk(32'hE9320070, 32'h200,     0, 0, 3, 32'h1F4,      32'h1F8,      32'h1FC,     4, 5, 6, 1, 1, 32'h1F4,      15, 3, 0));
      vecs.push_back(mk(32'hE8B20084, 32'h40,      0, 0, 2, 32'h40,       32'h44,       0,           2, 7, 0, 1, 0, 32'h48,       11, 2, 0));
      vecs.push_back(mk(32'hE8900000, 32'h300,     0, 0, 0, 0,            0,            0,           0, 0, 0, 1, 0, 32'h300,       2, 0, 0));
      vecs.push_back(mk(32'hE9810001, 32'h1000,    3, 0, 1, 32'h1004,     0,            0,           0, 0, 0, 0, 0, 32'h1004,     10, 4, 0));
      vecs.push_back(mk(32'hE8238001, 32'h10,      0, 0, 2, 32'hC,        32'h10,       0,           0, 15, 0, 0, 1, 32'h8,       11, 2, 0));
      vecs.push_back(mk(32'hE9350003, 32'h4,       0, 0, 2, 32'hFFFFFFFC, 32'h0,        0,           0, 1, 0, 1, 1, 32'hFFFFFFFC, 11, 2, 0));
      vecs.push_back(mk(32'hE8910008, 32'h80,      2, 0, 1, 32'h80,       0,            0,           3, 0, 0, 1, 0, 32'h84,        9, 3, 0));

      // Reset state
      #12;
      check("reset_outputs",
            {busy, done, MAR_ld, MDR_ld, RF_ld, R_W, MOV, wb_ld, err, reg_sel, mem_addr[15:0], wb_value[15:0]},
            64'd0);
      @(negedge clk);
      clr = 1'b1;

      // Non-block-transfer start must be ignored
      @(negedge clk);
      IR = 32'hE5900000; base = 32'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ignored_start_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("ignored_start_busy2", {63'd0, busy}, 64'd0);

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // Reset in the middle of a load memory phase
      @(negedge clk);
      IR = 32'hE9320070; base = 32'h200; start = 1'b1;
      @(negedge clk);
      start = 1'b0; MOC = 1'b0; found = 0;
      for (int c = 0; c < 20; c++) begin
         if (MOV) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      check("midreset_reached_lmem", 64'(found), 64'd1);
      #2 clr = 1'b0;
      #1;
      check("midreset_outputs",
            {busy, done, MAR_ld, MDR_ld, RF_ld, R_W, MOV, wb_ld, err, reg_sel, mem_addr[15:0], wb_value[15:0]},
            64'd0);
      check("midreset_addr_hi", {32'd0, mem_addr}, 64'd0);
      @(negedge clk);
      clr = 1'b1;
      run_vec(100, vecs[2]);

`ifdef MOC_TIMEOUT_EN
      run_vec(200, mk(32'hE8A00002, 32'h100, 1000, 0, 1, 32'h100, 0, 0, 1, 0, 0, 0, 0, 32'h104, 19, 15, 1));
      @(negedge clk);
      check("timeout_err_held", {63'd0, err}, 64'd1);
      run_vec(201, vecs[0]);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Sub-controller that sequences ARM addressing-mode-4 block transfers (LDM/STM) over the existing MAR/MDR/register-file/memory datapath. The main ControlUnit hands off via start and waits on done. The block issues one memory transaction per register in the list, in ascending register order, using the MOC handshake. It then produces the base-register writeback value.

Parameters:
ADDR_STEP, 4, byte increment between consecutive transfers
MAX_WAIT, 15, MOC wait cycles before timeout (used only with MOC_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset (0 = reset)
start  in  1  one-cycle request from ControlUnit; sampled only in IDLE
IR  in  32  instruction; uses [27:25], P=[24], U=[23], W=[21], L=[20], Rn=[19:16], list=[15:0]
base  in  32  current value of Rn, sampled on accepted start
MOC  in  1  memory operation complete
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
MAR_ld  out  1  load MAR from mem_addr
MDR_ld  out  1  load MDR (store: from RF port; load: from memory)
RF_ld  out  1  write MDR into register reg_sel
R_W  out  1  1 = read memory, 0 = write
MOV  out  1  memory operation valid
reg_sel  out  4  register currently transferred
mem_addr  out  32  transfer address
wb_ld  out  1  write wb_value into Rn
wb_value  out  32  final base value
err  out  1  MOC timeout flag (tied 0 without MOC_TIMEOUT_EN)

Behaviour:
- The clock is clk. Reset is clr, asynchronous and active-low. While clr=0, the state is IDLE, the working list is cleared, and all outputs are 0.
- A start is accepted only in IDLE with IR[27:25]=3'b100. Any other start is ignored (busy stays 0). A start while busy is ignored.
- States: IDLE, SETUP, ADDR, SMDR, SMEM, LMEM, LRF, NEXT, WB, DONE.
- IDLE -> SETUP on an accepted start. The block latches IR fields and base.
- SETUP, 1 cycle:
  - n = popcount(list).
  - Start address: IA (P=0,U=1) = base; IB (P=1,U=1) = base+4; DA (P=0,U=0) = base-4n+4; DB (P=1,U=0) = base-4n.
  - wb_value = base+4n if U=1, else base-4n.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
  - n=0 goes to DONE: no transfers, no writeback.
- ADDR, 1 cycle:
  - reg_sel = lowest set bit of the remaining list. mem_addr = current address. MAR_ld=1.
  - Goes to SMDR if L=0, LMEM if L=1.
- Store path:
  - SMDR, 1 cycle: MDR_ld=1.
  - SMEM: MOV=1, R_W=0, held until MOC=1, then NEXT.
- Load path:
  - LMEM: MOV=1, R_W=1, MDR_ld=1, held until MOC=1, then LRF.
  - LRF, 1 cycle: RF_ld=1.
- MOC sampled high in the first MEM cycle gives a 1-cycle memory phase.
- NEXT, 1 cycle: clear the transferred bit and add ADDR_STEP to the address. If the list is empty go to WB, else ADDR.
- WB, 1 cycle: wb_ld = W, except wb_ld=0 when L=1 and the Rn bit was set in the original list (the loaded value wins).
- DONE, 1 cycle: done=1, busy=0 on the next cycle, return to IDLE.
- mem_addr and reg_sel hold their values outside ADDR. The strobes are 0 in every state not listed above.
- Reset mid-transfer aborts immediately. No writeback occurs and MOV drops asynchronously.

Optional Feature:
MOC_TIMEOUT_EN:
- When defined, a 4-bit wait counter runs in SMEM/LMEM and resets on state entry.
- If MOC is still 0 after MAX_WAIT cycles: MOV drops, err=1, the block goes to DONE with no writeback.
- err holds until the next accepted start or reset.
- When undefined, the block waits for MOC indefinitely and err is tied 0.

Decomposition:
- Shared package ldm_stm_pkg holds:
  - the state enum;
  - ADDR_STEP;
  - IR field bit-position constants (P, U, W, L, Rn, list).
- One sub-module, reg_list_scan: combinational priority encoder returning the lowest set index plus popcount of a 16-bit list.

Test Plan:
1. STMIA R0!,{R1,R3}, base=0x100, MOC immediate -> mem_addr 0x100 (reg_sel 1) then 0x104 (reg_sel 3); R_W=0; wb_ld=1, wb_value=0x108; done 11 cycles after start.
2. LDMDB R2!,{R4,R5,R6}, base=0x200 -> addresses 0x1F4, 0x1F8, 0x1FC; three RF_ld pulses with reg_sel 4, 5, 6; R_W=1; wb_value=0x1F4.
3. LDMIA R2!,{R2,R7}, base=0x40 -> RF_ld on R2 and R7; wb_ld stays 0.
4. Empty list (IR=0xE8900000) -> done 2 cycles after start; no MAR_ld, MOV or wb_ld.
5. MOC delayed 3 cycles during a store -> MOV=1 for exactly 4 cycles. Then assert clr=0 mid-LMEM -> all outputs 0 immediately; next start runs cleanly.
6. With MOC_TIMEOUT_EN and MOC held 0 -> MOV drops after 15 wait cycles, err=1, done pulses, wb_ld=0.
